// File: rtl/wr_collect_buf.sv
`timescale 1ns/1ps
// Write-collecting line buffer: merges narrow byte-masked writes into one line
// and issues a single full-width SRAM write on miss, full, flush or idle timeout.
module wr_collect_buf #(
  parameter int WID  = 512,
  parameter int DEP  = 256,
  parameter int IWID = 64,
  parameter int TMO  = 15,
  localparam int NSEL = WID / 8,
  localparam int ISEL = IWID / 8,
  localparam int OW   = $clog2(WID / IWID),
  localparam int LW   = $clog2(DEP)
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LW+OW-1:0] req_adr,
  input  logic [ISEL-1:0]  req_sel,
  input  logic [IWID-1:0]  req_dat,
  input  logic             flush,
  output logic             wr,
  output logic [NSEL-1:0]  sel,
  output logic [LW-1:0]    wadr,
  output logic [WID-1:0]   o,
  output logic             empty
);
  localparam int CW = $clog2(TMO + 2);
  localparam logic [CW-1:0] TMO_C = CW'(TMO);

  function automatic logic [NSEL-1:0] place_sel(input logic [ISEL-1:0] s,
                                                input logic [OW-1:0] ofs);
    return NSEL'(s) << (int'(ofs) * ISEL);
  endfunction

  function automatic logic [WID-1:0] place_dat(input logic [IWID-1:0] d,
                                               input logic [OW-1:0] ofs);
    return WID'(d) << (int'(ofs) * IWID);
  endfunction

  logic            line_vld;
  logic [LW-1:0]   line_adr;
  logic [NSEL-1:0] line_mask;
  logic [WID-1:0]  line_dat;
  logic [CW-1:0]   idle_cnt;

  logic [LW-1:0]   req_line;
  logic [OW-1:0]   req_ofs;
  logic [NSEL-1:0] placed_sel;
  logic [WID-1:0]  placed_dat;
  logic [WID-1:0]  merged_dat;
  logic            hit, full, tmo_hit, drain, accept;

  assign req_line   = req_adr[LW+OW-1:OW];
  assign req_ofs    = req_adr[OW-1:0];
  assign placed_sel = place_sel(req_sel, req_ofs);
  assign placed_dat = place_dat(req_dat, req_ofs);

  assign hit       = line_vld && (req_line == line_adr);
  assign full      = line_vld && (&line_mask);
  assign tmo_hit   = line_vld && (idle_cnt == TMO_C);
  // A ready request while valid is always a clean hit, so drain and accept never coincide.
  assign req_ready = !line_vld || (hit && !flush && !full && !tmo_hit);
  assign drain     = line_vld && (flush || full || tmo_hit || (req_valid && !hit));
  assign accept    = req_valid && req_ready;
  assign empty     = !line_vld;

  always_comb begin
    merged_dat = line_vld ? line_dat : '0;
    for (int i = 0; i < NSEL; i++) begin
      if (placed_sel[i]) merged_dat[8*i +: 8] = placed_dat[8*i +: 8];
    end
  end

  // Collection state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_vld  <= 1'b0;
      line_mask <= '0;
      idle_cnt  <= '0;
    end else if (drain) begin
      line_vld  <= 1'b0;
      line_mask <= '0;
      idle_cnt  <= '0;
    end else if (accept) begin
      line_vld  <= 1'b1;
      line_mask <= (line_vld ? line_mask : '0) | placed_sel;
      idle_cnt  <= '0;
    end else if (line_vld && idle_cnt != TMO_C) begin
      idle_cnt  <= idle_cnt + 1'b1;
    end
  end

  // Line contents are qualified by line_vld and need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      line_dat <= merged_dat;
      if (!line_vld) line_adr <= req_line;
    end
  end

  // SRAM write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr   <= 1'b0;
      sel  <= '0;
      wadr <= '0;
      o    <= '0;
    end else begin
      wr <= drain;
      if (drain) begin
        sel  <= line_mask;
        wadr <= line_adr;
        o    <= line_dat;
      end
    end
  end

endmodule

// File: doc/wr_collect_buf.md
WR_COLLECT_BUF -- requirements
Module: wr_collect_buf

Interface
REQ-001 SHALL have parameter WID, default 512, meaning line width in bits driven to the line SRAM.
REQ-002 SHALL have parameter DEP, default 256, meaning number of lines in the line SRAM.
REQ-003 SHALL have parameter IWID, default 64, meaning request data width in bits; WID/IWID is a power of two.
REQ-004 SHALL have parameter TMO, default 15, meaning idle cycles before an unmerged buffer self-drains.
REQ-005 SHALL define derived widths: NSEL=WID/8, ISEL=IWID/8, OW=$clog2(WID/IWID), LW=$clog2(DEP).
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-008 SHALL have port req_valid  input  1  write request present.
REQ-009 SHALL have port req_ready  output  1  request accepted on an edge where req_valid && req_ready.
REQ-010 SHALL have port req_adr  input  LW+OW  [LW+OW-1:OW] line address, [OW-1:0] word offset.
REQ-011 SHALL have port req_sel  input  ISEL  byte enables of req_dat.
REQ-012 SHALL have port req_dat  input  IWID  write data.
REQ-013 SHALL have port flush  input  1  level request to drain the buffer.
REQ-014 SHALL have port wr  output  1  registered one-cycle line-write strobe to SRAM.
REQ-015 SHALL have port sel  output  NSEL  registered byte enables for the line write.
REQ-016 SHALL have port wadr  output  LW  registered line address for the line write.
REQ-017 SHALL have port o  output  WID  registered line write data.
REQ-018 SHALL have port empty  output  1  high when buffer holds no pending bytes.

Function
REQ-019 SHALL hold one line buffer: valid bit, line address, WID data, NSEL byte mask.
REQ-020 hit SHALL be valid && req_adr[LW+OW-1:OW]==buffered line address; full SHALL be valid && mask all ones; tmo_hit SHALL be valid && idle counter==TMO.
REQ-021 req_ready SHALL be combinational: !valid || (hit && !flush && !full && !tmo_hit).
REQ-022 drain SHALL be valid && (flush || full || tmo_hit || (req_valid && !hit)).
REQ-023 On accept with !valid: buffer SHALL load line address, mask = req_sel placed at byte offset req_adr[OW-1:0]*ISEL (others 0), data lanes likewise, valid<=1.
REQ-024 On accept with hit: enabled bytes SHALL overwrite buffered bytes; mask |= placed req_sel; disabled bytes unchanged.
REQ-025 Accept with req_sel==0 SHALL still be accepted and load/keep valid with unchanged mask contribution.
REQ-026 On a drain edge: wr<=1, sel<=mask, wadr<=line address, o<=data, valid<=0, mask<=0; no request accepted that edge.
REQ-027 On every non-drain edge wr<=0; sel, wadr, o SHALL hold last values.
REQ-028 Miss (req_valid && !hit while valid) SHALL cost exactly one stall cycle: drain edge, then request accepted next edge.
REQ-029 A request completing the mask SHALL produce wr in the cycle after the following edge (accept edge N, drain edge N+1, wr high N+1..N+2).
REQ-030 Idle counter SHALL reset to 0 on every accept and on drain, increment each cycle valid and no accept, saturate at TMO.
REQ-031 flush with !valid SHALL have no effect; flush held high SHALL keep req_ready low while valid.
REQ-032 empty SHALL equal !valid.
REQ-033 Back-to-back writes: wr SHALL never be high for two consecutive cycles (a reload cycle always intervenes).

Reset
REQ-034 While rst high: valid=0, mask=0, counter=0, wr=0, sel=0, wadr=0, o=0, empty=1; req_ready=1.
REQ-035 rst asserted mid-collection SHALL discard buffered bytes with no write issued.

Verification
REQ-036 Eight accepts to line 0x12, offsets 0..7, req_sel=0xFF, dat=offset*0x0101010101010101 -> one wr, wadr=0x12, sel=all ones, o lane k = k*0x0101010101010101.
REQ-037 Accept line 0x05 ofs 2 sel=0x0F, then line 0x06 ofs 0 -> req_ready low one cycle, wr with wadr=0x05, sel bits[19:16]=1 only, then line 0x06 loaded.
REQ-038 Two accepts same line ofs 1: sel=0xFF dat=0xAA.., then sel=0x01 dat=0x55 -> flush -> byte 8=0x55, bytes 9..15=0xAA, sel=0xFF00.
REQ-039 Single accept, no further traffic, TMO=15 -> wr asserted after exactly 15 idle cycles plus drain edge; empty returns to 1.
REQ-040 Accept 3 words then rst pulse -> wr never asserts, empty=1, next accept starts fresh mask.
